// File: rtl/dsp_sequencer_if.sv
// dsp_sequencer_if: host-side program load bus of the sequencer
interface dsp_sequencer_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 26
);
  logic                   prog_wr_en;
  logic [PC_WIDTH-1:0]    prog_wr_addr;
  logic [INSTR_WIDTH-1:0] prog_wr_data;
  logic                   prog_len_wr_en;
  logic [PC_WIDTH:0]      prog_len_data;
  logic                   prog_wr_err;
  modport master (
    output prog_wr_en, prog_wr_addr, prog_wr_data, prog_len_wr_en, prog_len_data,
    input  prog_wr_err
  );
  modport slave (
    input  prog_wr_en, prog_wr_addr, prog_wr_data, prog_len_wr_en, prog_len_data,
    output prog_wr_err
  );
endinterface

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: streams a host-loaded program to a dsp_core once per sample tick
module dsp_sequencer #(
  parameter int OPCODE_WIDTH      = 6,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int PARAM_ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH,
  parameter int PC_WIDTH          = 10,
  parameter int DRAIN_CYCLES      = 5,
  parameter int OVR_CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  dsp_sequencer_if.slave           host,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [OVR_CNT_WIDTH-1:0] overrun_count,
  input  logic                     overrun_clr
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [PC_WIDTH:0] LEN_MAX = {1'b1, {PC_WIDTH{1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d, last_q, last_d, rd_addr_q, rd_addr_d;
  logic [PC_WIDTH:0]        len_q, len_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     rd_vld_q, rd_vld_d, busy_q, busy_d, done_q, done_d;
  logic                     err_q, err_d, ovr_q, ovr_d, idle, ovr_evt;
  logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [INSTR_WIDTH-1:0]   mem [2**PC_WIDTH];
  always_comb begin
    idle    = state_q == IDLE;
    ovr_evt = sample_tick && !idle;
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (idle && sample_tick) begin
      state_d = (len_q == '0) ? DRAIN : RUN;
      pc_d    = '0;
      cnt_d   = '0;
      last_d  = PC_WIDTH'(len_q - 1'b1);
    end else if (state_q == RUN) begin
      pc_d = pc_q + 1'b1;
      if (pc_q == last_q) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
    end else if (state_q == DRAIN && !rd_vld_q) begin
      // drain is timed from the last issued word, so hold while a read is in flight
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = IDLE;
    end
    rd_vld_d  = state_q == RUN;
    rd_addr_d = pc_q;
    instr_d   = rd_vld_q ? mem[rd_addr_q] : '0;
    busy_d    = !idle;
    done_d    = busy_q && idle;
    err_d     = (host.prog_wr_en || host.prog_len_wr_en) && !idle;
    len_d     = (host.prog_len_wr_en && idle) ?
                ((host.prog_len_data > LEN_MAX) ? LEN_MAX : host.prog_len_data) : len_q;
    ovr_d     = !overrun_clr && (ovr_q || ovr_evt);
    ovr_cnt_d = overrun_clr ? '0 : (ovr_evt && !(&ovr_cnt_q)) ? ovr_cnt_q + 1'b1 : ovr_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      instr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (host.prog_wr_en && state_q == IDLE) mem[host.prog_wr_addr] <= host.prog_wr_data;
  end
  assign instruction      = instr_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign overrun          = ovr_q;
  assign overrun_count    = ovr_cnt_q;
  assign host.prog_wr_err = err_q;
endmodule
